// File: rtl/rand_multi.sv
// rand_multi: multi-channel uniform random-number server.
// Galois LFSR entropy, edge-queued requests, round-robin rejection sampler.
module rand_multi #(
    parameter int SIZE_BITS = 11,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 448,
    parameter int NUM_CH = 4,
    parameter int LFSR_BITS = 16,
    parameter logic [LFSR_BITS-1:0] TAPS = 16'hB400,
    parameter logic [LFSR_BITS-1:0] SEED = 16'hACE1,
    parameter int MAX_TRIES = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CH-1:0]           rise,
    output logic [NUM_CH*SIZE_BITS-1:0] dout,
    output logic [NUM_CH-1:0]           valid,
    output logic                        busy
);
    localparam int RANGE = MAX_VAL - MIN_VAL + 1;
    localparam int RBITS = ($clog2(RANGE) < 1) ? 1 : $clog2(RANGE);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [RBITS:0] RANGE_C = (RBITS+1)'(RANGE);
    localparam logic [SIZE_BITS-1:0] MIN_C = SIZE_BITS'(MIN_VAL);
    localparam logic [SIZE_BITS-1:0] RANGE_S = SIZE_BITS'(RANGE);
    localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);
    localparam logic [PW-1:0] LAST_CH = PW'(NUM_CH - 1);

    typedef enum logic {IDLE, DRAW} state_t;

    state_t                 state, state_n;
    logic [LFSR_BITS-1:0]   lfsr, lfsr_n;
    logic [NUM_CH-1:0]      rise_d, pending, pending_n;
    logic [NUM_CH-1:0]      edges, clr;
    logic [PW-1:0]          rr_ptr, rr_n;
    logic [PW-1:0]          grant, grant_n;
    logic [PW-1:0]          pick, idx;
    logic                   found;
    logic [TW-1:0]          tries, tries_n;
    logic [RBITS:0]         cand;
    logic                   accept, done;
    logic [SIZE_BITS-1:0]   result;

    assign edges  = rise & ~rise_d;
    assign cand   = {1'b0, lfsr[RBITS-1:0]};
    assign accept = cand < RANGE_C;
    assign busy   = (state == DRAW);
    assign clr    = done ? (NUM_CH'(1) << grant) : '0;
    // A fresh edge on the channel being completed keeps its request alive
    assign pending_n = (pending & ~clr) | edges;

    always_comb begin
        lfsr_n = lfsr;
        if (lfsr == '0)
            lfsr_n = SEED;
        else if (state == DRAW)
            lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    end

    // Scan downwards so the channel closest to rr_ptr wins
    always_comb begin
        pick  = rr_ptr;
        idx   = rr_ptr;
        found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = PW'((int'(rr_ptr) + k) % NUM_CH);
            if (pending[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        tries_n = tries;
        rr_n    = rr_ptr;
        done    = 1'b0;
        result  = MIN_C + SIZE_BITS'(cand);
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_n = pick;
                    tries_n = '0;
                    state_n = DRAW;
                end
            end
            DRAW: begin
                if (accept) begin
                    done = 1'b1;
                end else if (tries == LAST_TRY) begin
                    done   = 1'b1;
                    result = MIN_C + SIZE_BITS'(cand) - RANGE_S;
                end else begin
                    tries_n = tries + 1'b1;
                end
                if (done) begin
                    state_n = IDLE;
                    rr_n    = (grant == LAST_CH) ? '0 : grant + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lfsr    <= SEED;
            rise_d  <= '0;
            pending <= '0;
            rr_ptr  <= '0;
            grant   <= '0;
            tries   <= '0;
            valid   <= '0;
            dout    <= {NUM_CH{MIN_C}};
        end else begin
            state   <= state_n;
            lfsr    <= lfsr_n;
            rise_d  <= rise;
            pending <= pending_n;
            rr_ptr  <= rr_n;
            grant   <= grant_n;
            tries   <= tries_n;
            valid   <= clr;
            if (done)
                dout[grant*SIZE_BITS +: SIZE_BITS] <= result;
        end
    end
endmodule

// File: tb/tb_rand_multi.sv
// tb_rand_multi: directed vectors for rand_multi, default and
// degenerate / fallback / full-range configurations.
module tb_rand_multi;
    localparam int SB = 11;
    localparam int NC = 4;

    typedef struct { int ch; int val; int lat; } vec_t;
    typedef struct { int ch; int val; int cyc; } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NC-1:0] rise = '0;
    logic [NC*SB-1:0] dout;
    logic [NC-1:0] valid;
    logic          busy;
    logic          rise_s = 1'b0;
    logic [SB-1:0] dout_d, dout_f, dout_u;
    logic          valid_d, valid_f, valid_u;
    logic          busy_d, busy_f, busy_u;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  evq[$];

    rand_multi u_dut (
        .clk(clk), .reset(reset), .rise(rise),
        .dout(dout), .valid(valid), .busy(busy)
    );

    rand_multi #(.MIN_VAL(10), .MAX_VAL(10), .NUM_CH(1), .MAX_TRIES(1)) u_deg (
        .clk(clk), .reset(reset), .rise(rise_s),
        .dout(dout_d), .valid(valid_d), .busy(busy_d)
    );

    rand_multi #(.MIN_VAL(0), .MAX_VAL(4), .NUM_CH(1), .MAX_TRIES(1)) u_fb (
        .clk(clk), .reset(reset), .rise(rise_s),
        .dout(dout_f), .valid(valid_f), .busy(busy_f)
    );

    rand_multi #(.MIN_VAL(0), .MAX_VAL(2047), .NUM_CH(1)) u_full (
        .clk(clk), .reset(reset), .rise(rise_s),
        .dout(dout_u), .valid(valid_u), .busy(busy_u)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        for (int i = 0; i < NC; i++)
            if (valid[i] === 1'b1)
                evq.push_back('{i, int'(dout[i*SB +: SB]), cyc});

    function automatic logic [15:0] nxt(logic [15:0] x);
        if (x == 16'h0) return 16'hACE1;
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_ev(int n, int budget);
        int k = 0;
        while (evq.size() < n && k < budget) begin
            step();
            k++;
        end
    endtask

    task automatic expect_ev(string nm, int ch, int val, int at);
        ev_t e;
        if (evq.size() == 0) begin
            chk({nm, "_present"}, 0, 1);
            return;
        end
        e = evq.pop_front();
        chk({nm, "_ch"}, e.ch, ch);
        chk({nm, "_val"}, e.val, val);
        if (at >= 0) chk({nm, "_cyc"}, e.cyc, at);
    endtask

    initial begin
        vec_t        tbl[4];
        int          hold[4];
        int          exp_b[4];
        int          c0, ef, eu;
        logic [15:0] m;
        logic        ok;

        // Hand-computed draws from SEED 0xACE1, 9-bit candidates
        tbl[0] = '{0, 225, 3};
        tbl[1] = '{2, 112, 3};
        tbl[2] = '{1, 312, 3};
        tbl[3] = '{3, 156, 3};
        hold   = '{225, 312, 112, 156};
        exp_b  = '{78, 39, 275, 393};

        repeat (3) step();
        for (int i = 0; i < NC; i++)
            chk($sformatf("rst_dout%0d", i), int'(dout[i*SB +: SB]), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_deg_dout", int'(dout_d), 10);
        reset = 1'b0;
        repeat (20) step();
        chk("idle_no_valid", evq.size(), 0);

        for (int t = 0; t < 4; t++) begin
            rise[tbl[t].ch] = 1'b1;
            c0 = cyc;
            step();
            rise = '0;
            chk($sformatf("req%0d_busy_idle", t), int'(busy), 0);
            step();
            chk($sformatf("req%0d_busy_draw", t), int'(busy), 1);
            wait_ev(1, 20);
            repeat (3) step();
            expect_ev($sformatf("req%0d", t), tbl[t].ch, tbl[t].val,
                      c0 + tbl[t].lat);
            chk($sformatf("req%0d_extra", t), evq.size(), 0);
        end
        for (int i = 0; i < NC; i++)
            chk($sformatf("hold%0d", i), int'(dout[i*SB +: SB]), hold[i]);

        rise = 4'hF;
        c0 = cyc;
        repeat (50) step();
        rise = '0;
        repeat (3) step();
        chk("burst_count", evq.size(), 4);
        for (int j = 0; j < 4; j++)
            expect_ev($sformatf("burst%0d", j), j, exp_b[j], c0 + 3 + 2*j);

        rise = 4'b1001;
        c0 = cyc;
        step();
        rise = '0;
        wait_ev(2, 30);
        repeat (4) step();
        expect_ev("rr_ch0", 0, 196, c0 + 3);
        expect_ev("rr_ch3", 3, 354, c0 + 5);
        chk("rr_extra", evq.size(), 0);

        rise = 4'b0011;
        c0 = cyc;
        step();
        rise = '0;
        step();
        rise[1] = 1'b1;
        step();
        rise = '0;
        repeat (20) step();
        expect_ev("merge_ch0", 0, 177, c0 + 3);
        expect_ev("merge_ch1", 1, 88, c0 + 5);
        chk("merge_extra", evq.size(), 0);

        rise[1] = 1'b1;
        c0 = cyc;
        step();
        rise = '0;
        step();
        rise[1] = 1'b1;
        step();
        rise = '0;
        repeat (20) step();
        expect_ev("cmpl_first", 1, 44, c0 + 3);
        expect_ev("cmpl_second", 1, 278, c0 + 5);
        chk("cmpl_extra", evq.size(), 0);

        rise[2] = 1'b1;
        step();
        rise = '0;
        step();
        chk("mid_busy", int'(busy), 1);
        reset = 1'b1;
        step();
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(valid), 0);
        for (int i = 0; i < NC; i++)
            chk($sformatf("mid_rst_dout%0d", i), int'(dout[i*SB +: SB]), 0);
        step();
        reset = 1'b0;
        repeat (10) step();
        chk("mid_no_valid", evq.size(), 0);
        rise[2] = 1'b1;
        c0 = cyc;
        step();
        rise = '0;
        wait_ev(1, 20);
        repeat (3) step();
        expect_ev("post_rst", 2, 225, c0 + 3);
        chk("post_rst_extra", evq.size(), 0);

        m = 16'hACE1;
        for (int r = 0; r < 1000; r++) begin
            ef = (m[2:0] < 3'd5) ? int'(m[2:0]) : int'(m[2:0]) - 5;
            eu = int'(m[10:0]);
            rise_s = 1'b1;
            step();
            rise_s = 1'b0;
            step();
            ok = !valid_d && !valid_f && !valid_u && busy_d && busy_f && busy_u;
            step();
            ok = ok && valid_d && valid_f && valid_u;
            chk($sformatf("aux%0d_lat", r), int'(ok), 1);
            chk($sformatf("aux%0d_deg", r), int'(dout_d), 10);
            chk($sformatf("aux%0d_fb", r), int'(dout_f), ef);
            chk($sformatf("aux%0d_fb_range", r), int'(dout_f <= 11'd4), 1);
            chk($sformatf("aux%0d_full", r), int'(dout_u), eu);
            step();
            m = nxt(m);
        end
        chk("aux_main_quiet", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
